// File: rtl/uart_rx_ctrl.sv
// UART receiver control stage: frame FSM, edge/bit counters, 3-sample
// majority vote and the enable/valid pulses for the deserializer and checkers.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic                  sampled_bit,
  output logic                  deser_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  strt_glitch,
  output logic                  data_valid,
  output logic                  busy
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0]      LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]      BIT_ONE  = BIT_W'(1);
  localparam logic [PRESCALE_W-1:0] CNT_ZERO = '0;
  localparam logic [PRESCALE_W-1:0] CNT_ONE  = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] CNT_TWO  = PRESCALE_W'(2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  par_en_q;
  logic                  samp_a;
  logic                  samp_b;

  logic [PRESCALE_W-1:0] half_p;
  logic [PRESCALE_W-1:0] last_edge;
  logic [PRESCALE_W-1:0] samp_a_edge;
  logic [PRESCALE_W-1:0] samp_b_edge;
  logic                  bit_end;
  logic                  vote_now;
  logic                  vote;

  // Sample points and bit boundary derived from the prescale latched for this
  // frame; arithmetic wraps so illegal ratios still give a bounded bit period.
  always_comb begin
    half_p      = prescale_q >> 1;
    last_edge   = prescale_q - CNT_ONE;
    samp_a_edge = half_p - CNT_TWO;
    samp_b_edge = half_p - CNT_ONE;
    bit_end     = (edge_cnt == last_edge);
    vote_now    = (edge_cnt == half_p);
    vote        = (samp_a & samp_b) | (samp_a & RX_IN) | (samp_b & RX_IN);
  end

  // Capture the first two of the three RX_IN samples around mid-bit; the
  // third is taken live when the vote is registered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      samp_a <= 1'b0;
      samp_b <= 1'b0;
    end else if (state != IDLE) begin
      if (edge_cnt == samp_a_edge) samp_a <= RX_IN;
      if (edge_cnt == samp_b_edge) samp_b <= RX_IN;
    end
  end

  // Frame FSM with counters and registered pulse outputs; pulses default low
  // each cycle so every enable lasts exactly one clock.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      edge_cnt    <= CNT_ZERO;
      bit_cnt     <= '0;
      prescale_q  <= CNT_ZERO;
      par_en_q    <= 1'b0;
      sampled_bit <= 1'b0;
      deser_en    <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
      strt_glitch <= 1'b0;
      data_valid  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      deser_en    <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
      strt_glitch <= 1'b0;
      data_valid  <= 1'b0;
      if (state == IDLE) begin
        edge_cnt <= CNT_ZERO;
        bit_cnt  <= '0;
        if (!RX_IN) begin
          state      <= START;
          busy       <= 1'b1;
          prescale_q <= Prescale;
          par_en_q   <= PAR_EN;
        end
      end else begin
        edge_cnt <= bit_end ? CNT_ZERO : edge_cnt + CNT_ONE;
        if (vote_now) begin
          sampled_bit <= vote;
          case (state)
            DATA:    deser_en   <= 1'b1;
            PARITY:  par_chk_en <= 1'b1;
            STOP:    stp_chk_en <= 1'b1;
            default: ;
          endcase
        end
        if (bit_end) begin
          case (state)
            START: begin
              if (sampled_bit) begin
                strt_glitch <= 1'b1;
                busy        <= 1'b0;
                state       <= IDLE;
              end else begin
                bit_cnt <= '0;
                state   <= DATA;
              end
            end
            DATA: begin
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                state   <= par_en_q ? PARITY : STOP;
              end else begin
                bit_cnt <= bit_cnt + BIT_ONE;
              end
            end
            PARITY: state <= STOP;
            STOP: begin
              data_valid <= ~stp_err & ~(par_en_q & par_err);
              busy       <= 1'b0;
              state      <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frame drivers queue the expected frame
// outcome, a monitor tallies pulses per frame and compares when busy drops.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b1;
  logic       par_err = 1'b0;
  logic       stp_err = 1'b0;
  logic       sampled_bit;
  logic       deser_en;
  logic       par_chk_en;
  logic       stp_chk_en;
  logic       strt_glitch;
  logic       data_valid;
  logic       busy;

  typedef struct {
    bit         valid;
    bit         glitch;
    int         deser;
    int         par;
    int         stp;
    logic [7:0] data;
    int         endCyc;
    bit         full;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         deserCnt = 0;
  int         parCnt = 0;
  int         stpCnt = 0;
  logic [7:0] shreg = 8'h00;
  logic       prevBusy = 1'b0;

  uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .PAR_EN     (PAR_EN),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .sampled_bit(sampled_bit),
    .deser_en   (deser_en),
    .par_chk_en (par_chk_en),
    .stp_chk_en (stp_chk_en),
    .strt_glitch(strt_glitch),
    .data_valid (data_valid),
    .busy       (busy)
  );

  // Free-running oversampling clock
  always #5 CLK = ~CLK;

  // Cycle counter used to time-stamp frame completion
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic closeFrame();
    exp_t e;
    if (sbq.size() == 0) begin
      checkOutput("unexpectedFrameEnd", 1, 0);
    end else begin
      e = sbq.pop_front();
      checkOutput("dataValid", data_valid, e.valid);
      checkOutput("strtGlitch", strt_glitch, e.glitch);
      if (e.full) begin
        checkOutput("deserCount", deserCnt, e.deser);
        checkOutput("parChkCount", parCnt, e.par);
        checkOutput("stpChkCount", stpCnt, e.stp);
        checkOutput("endCycle", cyc, e.endCyc);
        if (!e.glitch) checkOutput("dataBits", shreg, e.data);
      end
    end
    deserCnt = 0;
    parCnt   = 0;
    stpCnt   = 0;
    shreg    = 8'h00;
  endtask

  // Monitor: tally pulses while busy and score the frame when busy falls
  always @(negedge CLK) begin
    if (busy) begin
      if (deser_en) begin
        deserCnt++;
        shreg = {sampled_bit, shreg[7:1]};
      end
      if (par_chk_en) parCnt++;
      if (stp_chk_en) stpCnt++;
    end
    if (prevBusy && !busy) closeFrame();
    else if (data_valid || strt_glitch) checkOutput("strayPulse", 1, 0);
    prevBusy = busy;
  end

  task automatic checkAllLow(input string tag);
    checkOutput({tag, "_sampled_bit"}, sampled_bit, 0);
    checkOutput({tag, "_deser_en"}, deser_en, 0);
    checkOutput({tag, "_par_chk_en"}, par_chk_en, 0);
    checkOutput({tag, "_stp_chk_en"}, stp_chk_en, 0);
    checkOutput({tag, "_strt_glitch"}, strt_glitch, 0);
    checkOutput({tag, "_data_valid"}, data_valid, 0);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input int p, input bit parEn,
                               input bit parErrIn, input bit stpErrIn, input int spikeAt,
                               input int abortAt, input int changeAt, input bit late,
                               input int trailIdle);
    logic [10:0] bits;
    int   nbits;
    int   total;
    exp_t e;
    nbits = parEn ? 11 : 10;
    total = nbits * p;
    bits  = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = data[i];
    if (parEn) bits[9] = ^data;
    bits[nbits-1] = 1'b1;
    for (int c = 0; c < total; c++) begin
      @(negedge CLK);
      if (c == abortAt) begin
        #2;
        RST   = 1'b1;
        RX_IN = 1'b1;
        @(negedge CLK);
        checkAllLow("midReset");
        RST     = 1'b0;
        par_err = 1'b0;
        stp_err = 1'b0;
        repeat (trailIdle) @(negedge CLK);
        return;
      end
      if (c == 0) begin
        Prescale = 6'(p);
        PAR_EN   = parEn;
        e.valid  = !(stpErrIn || (parEn && parErrIn)) && (abortAt < 0);
        e.glitch = 1'b0;
        e.deser  = 8;
        e.par    = parEn ? 1 : 0;
        e.stp    = 1;
        e.data   = data;
        e.endCyc = cyc + 1 + (late ? 1 : 0) + total;
        e.full   = (abortAt < 0);
        sbq.push_back(e);
      end
      if (c == changeAt) begin
        Prescale = 6'd32;
        PAR_EN   = !parEn;
      end
      RX_IN = (c == spikeAt) ? 1'b0 : bits[c/p];
      if (c / p == nbits - 1) begin
        par_err = parErrIn;
        stp_err = stpErrIn;
      end
    end
    for (int i = 0; i < trailIdle; i++) begin
      @(negedge CLK);
      RX_IN = 1'b1;
      if (i == 1) begin
        par_err = 1'b0;
        stp_err = 1'b0;
      end
    end
  endtask

  task automatic applyGlitch(input int p);
    exp_t e;
    @(negedge CLK);
    Prescale = 6'(p);
    PAR_EN   = 1'b1;
    e.valid  = 1'b0;
    e.glitch = 1'b1;
    e.deser  = 0;
    e.par    = 0;
    e.stp    = 0;
    e.data   = 8'h00;
    e.endCyc = cyc + 1 + p;
    e.full   = 1'b1;
    sbq.push_back(e);
    RX_IN = 1'b0;
    @(negedge CLK);
    RX_IN = 1'b0;
    @(negedge CLK);
    RX_IN = 1'b1;
    repeat (3 * p) @(negedge CLK);
  endtask

  // Directed sequence of frames followed by a bounded scoreboard drain
  initial begin
    repeat (3) @(negedge CLK);
    checkAllLow("reset");
    RST = 1'b0;
    repeat (3) @(negedge CLK);

    //            data   P  par pe se spike abort chg late idle
    applyStimulus(8'hA5, 8,  1, 0, 0, -1,   -1,  -1, 0,   5);
    applyStimulus(8'h3C, 16, 0, 0, 0, -1,   -1,  -1, 0,   5);
    applyGlitch(8);
    applyStimulus(8'h0F, 8,  1, 1, 0, -1,   -1,  -1, 0,   5);
    applyStimulus(8'hF0, 8,  0, 0, 1, -1,   -1,  -1, 0,   5);
    applyStimulus(8'h69, 8,  0, 1, 0, -1,   -1,  -1, 0,   5);
    applyStimulus(8'h96, 8,  1, 0, 0, -1,   -1,  -1, 0,   5);
    applyStimulus(8'h81, 32, 0, 0, 0, 48,   -1,  -1, 0,   5);
    applyStimulus(8'h5A, 8,  1, 0, 0, -1,   45,  -1, 0,   5);
    applyStimulus(8'h33, 8,  1, 0, 0, -1,   -1,  -1, 0,   5);
    applyStimulus(8'hC3, 8,  1, 0, 0, -1,   -1,  20, 0,   5);
    applyStimulus(8'h55, 8,  1, 0, 0, -1,   -1,  -1, 0,   0);
    applyStimulus(8'hAA, 8,  1, 0, 0, -1,   -1,  -1, 1,   5);

    for (int i = 0; i < 1000 && sbq.size() != 0; i++) @(negedge CLK);
    checkOutput("sbDrained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
